mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 51 +++++
 rtl/mem_arbiter.sv | 102 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Two-port memory arbiter bus: requester ports 0/1
// plus the data-memory side and the busy flag.
interface mem_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 16
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          gnt0;
  logic          rvalid0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          gnt1;
  logic          rvalid1;
  logic [DW-1:0] rdata1;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_write;
  logic          mem_read;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  mem_rdata,
    output gnt0, rvalid0, rdata0,
    output gnt1, rvalid1, rdata1,
    output mem_addr, mem_wdata,
    output mem_write, mem_read,
    output busy
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output mem_rdata,
    input  gnt0, rvalid0, rdata0,
    input  gnt1, rvalid1, rdata1,
    input  mem_addr, mem_wdata,
    input  mem_write, mem_read,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin two-port arbiter for a single-cycle data
// memory: IDLE -> ACCESS -> RESP, one transaction per 3 cycles.
module mem_arbiter #(
  parameter int AW = 8,
  parameter int DW = 16
) (
  input  logic clk,
  input  logic rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_last;
  logic          r_win;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          w_req;
  logic          w_sel;
  logic          w_grant;

  assign w_req   = bus.req0 | bus.req1;
  assign w_grant = (r_state == IDLE) & w_req;

  // On a tie the port that did not win last time goes
  assign w_sel = (bus.req0 & bus.req1) ? ~r_last
                                       : bus.req1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last  <= 1'b1;
      r_win   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      if (w_grant) begin
        r_last  <= w_sel;
        r_win   <= w_sel;
        r_we    <= w_sel ? bus.we1 : bus.we0;
        r_addr  <= w_sel ? bus.addr1 : bus.addr0;
        r_wdata <= w_sel ? bus.wdata1 : bus.wdata0;
      end
      if (r_state == ACCESS && !r_we) begin
        r_rdata <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.rvalid0   = 1'b0;
    bus.rvalid1   = 1'b0;
    bus.rdata0    = '0;
    bus.rdata1    = '0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_write = 1'b0;
    bus.mem_read  = 1'b0;
    bus.busy      = (r_state != IDLE);
    unique case (r_state)
      IDLE: begin
        if (w_req) w_next = ACCESS;
      end
      ACCESS: begin
        w_next        = RESP;
        bus.gnt0      = ~r_win;
        bus.gnt1      = r_win;
        bus.mem_addr  = r_addr;
        bus.mem_wdata = r_wdata;
        bus.mem_write = r_we;
        bus.mem_read  = ~r_we;
      end
      RESP: begin
        w_next      = IDLE;
        bus.rvalid0 = ~r_win;
        bus.rvalid1 = r_win;
        if (!r_we && !r_win) bus.rdata0 = r_rdata;
        if (!r_we && r_win)  bus.rdata1 = r_rdata;
      end
      default: w_next = IDLE;
    endcase
  end
endmodule
